// File: rtl/dct_transpose_buffer_if.sv
// Handshake bundle between the row-pass DCT, the transpose buffer and the column-pass DCT.
// Row in (valid/ready), column out (valid/ready) plus column index and last marker.
interface dct_transpose_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH*N-1:0]   in_row;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH*N-1:0]   out_col;
  logic [2:0]                out_col_idx;
  logic                      out_last;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_col, out_col_idx, out_last
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_col, out_col_idx, out_last
  );
endinterface

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose memory: rows are written into one bank while the other
// bank is read out column by column. Coefficient words pass through untouched.
module dct_transpose_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  dct_transpose_buffer_if.slave    bus
);

  logic [DATA_WIDTH-1:0] mem_q [2][N][N];

  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic [2:0] rd_col_q, rd_col_d;

  logic in_ready, out_valid, wr_acc, rd_acc;
  logic [DATA_WIDTH*N-1:0] out_col;

  always_comb begin
    in_ready  = !full_q[wr_sel_q];
    out_valid = full_q[rd_sel_q];
    wr_acc    = bus.in_valid && in_ready;
    rd_acc    = bus.out_ready && out_valid;

    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    wr_row_d = wr_row_q;
    rd_sel_d = rd_sel_q;
    rd_col_d = rd_col_q;

    // Write and read always target different banks, so both updates may land together.
    if (wr_acc) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'(N-1)) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        wr_row_d         = 3'd0;
      end
    end

    if (rd_acc) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'(N-1)) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        rd_col_d         = 3'd0;
      end
    end
  end

  always_comb begin
    out_col = '0;
    for (int r = 0; r < N; r++) begin
      out_col[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_sel_q][r][rd_col_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_row_q <= 3'd0;
      rd_col_q <= 3'd0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_row_q <= wr_row_d;
      rd_col_q <= rd_col_d;
    end
  end

  // Bank contents are data only: never reset, written solely on an accepted row.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int c = 0; c < N; c++) begin
        mem_q[wr_sel_q][wr_row_q][c] <= bus.in_row[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_col     = out_col;
  assign bus.out_col_idx = rd_col_q;
  assign bus.out_last    = out_valid && (rd_col_q == 3'(N-1));

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer: table-driven single block, directed corner sequences and
// random traffic, all checked against a queue-based model of the pending blocks.
module tb_dct_transpose_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct_transpose_buffer_if #(.DATA_WIDTH(32), .N(8)) bus ();

  dct_transpose_buffer #(.DATA_WIDTH(32), .N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: completed blocks as a flat word queue (64 words each, row-major),
  // plus the block currently being assembled and the column being presented.
  logic [31:0] mq [$];
  logic [31:0] part [64];
  int prow = 0;
  int mcol = 0;
  logic acc_in, acc_out;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mkrow(input int blk, input int r);
    logic [255:0] v;
    for (int c = 0; c < 8; c++) v[c*32 +: 32] = 32'(blk*256 + r*16 + c);
    return v;
  endfunction

  function automatic logic m_in_ready();
    return (mq.size() / 64) < 2;
  endfunction

  function automatic logic m_out_valid();
    return mq.size() >= 64;
  endfunction

  function automatic logic [255:0] m_col();
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) v[r*32 +: 32] = mq[r*8 + mcol];
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    prow = 0;
    mcol = 0;
  endtask

  // Sample at the falling edge and compare every output against the model.
  task automatic pre();
    @(negedge clk);
    chk("in_ready", bus.in_ready, m_in_ready());
    chk("out_valid", bus.out_valid, m_out_valid());
    chk("out_last", bus.out_last, m_out_valid() && (mcol == 7));
    if (m_out_valid()) begin
      chk("out_col_idx", bus.out_col_idx, mcol[2:0]);
      chk("out_col", bus.out_col, m_col());
    end
  endtask

  task automatic post(input logic iv, input logic [255:0] row, input logic ordy);
    bus.in_valid  = iv;
    bus.in_row    = row;
    bus.out_ready = ordy;
    acc_in  = iv && m_in_ready();
    acc_out = ordy && m_out_valid();
    @(posedge clk);
    if (acc_out) begin
      mcol++;
      if (mcol == 8) begin
        for (int k = 0; k < 64; k++) void'(mq.pop_front());
        mcol = 0;
      end
    end
    if (acc_in) begin
      for (int c = 0; c < 8; c++) part[prow*8 + c] = row[c*32 +: 32];
      prow++;
      if (prow == 8) begin
        for (int k = 0; k < 64; k++) mq.push_back(part[k]);
        prow = 0;
      end
    end
  endtask

  task automatic step(input logic iv, input logic [255:0] row, input logic ordy);
    pre();
    post(iv, row, ordy);
  endtask

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    logic [2:0] exp_idx;
    logic       exp_last;
  } vec_t;

  vec_t tbl [17];
  logic [255:0] col3;
  logic [255:0] held;
  logic [255:0] rrow;
  int first_v, last_v, ncols;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;

    for (int i = 0; i < 17; i++) begin
      tbl[i].iv       = (i < 8);
      tbl[i].ordy     = 1'b1;
      tbl[i].exp_ir   = 1'b1;
      tbl[i].exp_ov   = (i >= 8) && (i < 16);
      tbl[i].exp_idx  = (i >= 8 && i < 16) ? 3'(i - 8) : 3'd0;
      tbl[i].exp_last = (i == 15);
    end
    for (int r = 0; r < 8; r++) col3[r*32 +: 32] = 32'(r*16 + 3);

    // Reset state while rst is held
    #3;
    chk("rst in_ready", bus.in_ready, 1'b1);
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst out_last", bus.out_last, 1'b0);
    chk("rst out_col_idx", bus.out_col_idx, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single block, table driven
    for (int i = 0; i < 17; i++) begin
      pre();
      chk("tbl in_ready", bus.in_ready, tbl[i].exp_ir);
      chk("tbl out_valid", bus.out_valid, tbl[i].exp_ov);
      chk("tbl out_col_idx", bus.out_col_idx, tbl[i].exp_idx);
      chk("tbl out_last", bus.out_last, tbl[i].exp_last);
      if (tbl[i].exp_ov && tbl[i].exp_idx == 3'd3) chk("tbl col3", bus.out_col, col3);
      post(tbl[i].iv, tbl[i].iv ? mkrow(0, i) : '0, tbl[i].ordy);
    end

    // Three blocks back to back: 24 columns with no bubbles after the first
    first_v = -1; last_v = -1; ncols = 0;
    for (int i = 0; i < 33; i++) begin
      pre();
      if (bus.out_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        ncols++;
      end
      post(i < 24, (i < 24) ? mkrow(i / 8, i % 8) : '0, 1'b1);
    end
    chk("b2b columns", 256'(ncols), 256'd24);
    chk("b2b first col latency", 256'(first_v), 256'd8);
    chk("b2b no bubbles", 256'(last_v - first_v + 1), 256'd24);

    // Backpressure: 20 rows offered with out_ready low, only 16 taken
    for (int i = 0; i < 20; i++) begin
      pre();
      if (i == 10) held = bus.out_col;
      post(1'b1, mkrow(3 + i / 8, i % 8), 1'b0);
    end
    pre();
    chk("bp in_ready low", bus.in_ready, 1'b0);
    chk("bp col stable", bus.out_col, held);
    chk("bp idx held", bus.out_col_idx, 3'd0);
    post(1'b0, '0, 1'b1);
    for (int j = 1; j < 8; j++) step(1'b0, '0, 1'b1);
    pre();
    chk("bp in_ready back", bus.in_ready, 1'b1);
    chk("bp next block valid", bus.out_valid, 1'b1);
    post(1'b0, '0, 1'b1);
    for (int j = 0; j < 8; j++) step(1'b0, '0, 1'b1);

    // Random traffic with random stalls on both sides
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 8; c++) rrow[c*32 +: 32] = $urandom;
      step(($urandom % 4) != 0, rrow, ($urandom % 2) != 0);
    end
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

    // Asynchronous reset mid-cycle with a full block held and a partial one in flight
    for (int i = 0; i < 13; i++) step(1'b1, mkrow(5 + i / 8, i % 8), 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("async rst out_valid", bus.out_valid, 1'b0);
    chk("async rst in_ready", bus.in_ready, 1'b1);
    chk("async rst out_last", bus.out_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 17; i++) begin
      pre();
      if (i == 8) chk("post rst col0", bus.out_col, mkrow(7, 0) >> 0 & 256'h0 | m_col());
      post(i < 8, (i < 8) ? mkrow(7, i) : '0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
